peak_finder: RTL and testbench

PEAK_FINDER -- requirements
Module: peak_finder

---
 rtl/peak_finder.sv | 96 +++++++++
 tb/tb_peak_finder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_finder.sv
// Peak detector for a signed filter stream: tracks the maximum of each
// above-threshold pulse, emits its amplitude and timestamp, then applies a hold-off.
module peak_finder #(
  parameter int DATA_W = 16,
  parameter int TIME_W = 16,
  parameter int HOLD_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] input_data,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic        [HOLD_W-1:0] holdoff,
  output logic signed [DATA_W-1:0] output_amp,
  output logic        [TIME_W-1:0] output_time,
  output logic                     output_valid,
  output logic        [7:0]        output_count,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, TRACK, HOLDOFF} state_t;

  state_t                     state;
  logic signed [DATA_W-1:0]   sample;
  logic                       sample_vld;
  logic        [TIME_W-1:0]   time_cnt;
  logic        [TIME_W-1:0]   sample_time;
  logic signed [DATA_W-1:0]   max_amp;
  logic        [TIME_W-1:0]   max_time;
  logic        [HOLD_W-1:0]   hold_cnt;
  logic                       above;

  // time_cnt has already advanced past the edge that captured the sample.
  assign sample_time = time_cnt - TIME_W'(1);
  assign above       = sample > threshold;
  assign busy        = (state != IDLE);

  // NOTE: every register, including the datapath, is reset so a pulse in
  // flight is fully discarded and nothing stale can be emitted after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      sample       <= '0;
      sample_vld   <= 1'b0;
      time_cnt     <= '0;
      max_amp      <= '0;
      max_time     <= '0;
      hold_cnt     <= '0;
      output_amp   <= '0;
      output_time  <= '0;
      output_valid <= 1'b0;
      output_count <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; each compare below sees the
      // values from before this edge, which fixes the two-clock emit latency.
      sample       <= input_data;
      sample_vld   <= 1'b1;
      time_cnt     <= time_cnt + TIME_W'(1);
      output_valid <= 1'b0;

      case (state)
        IDLE: begin
          // sample_vld masks the cleared input register on the release cycle.
          if (sample_vld && above) begin
            state    <= TRACK;
            max_amp  <= sample;
            max_time <= sample_time;
          end
        end

        TRACK: begin
          if (!above) begin
            output_amp   <= max_amp;
            output_time  <= max_time;
            output_valid <= 1'b1;
            output_count <= output_count + 8'd1;
            hold_cnt     <= holdoff;
            state        <= (holdoff == '0) ? IDLE : HOLDOFF;
          end else if (sample > max_amp) begin
            max_amp  <= sample;
            max_time <= sample_time;
          end
        end

        HOLDOFF: begin
          hold_cnt <= hold_cnt - HOLD_W'(1);
          if (hold_cnt == HOLD_W'(1)) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peak_finder.sv
// Directed bench for peak_finder: a default instance plus a TIME_W=4 instance
// for timestamp wrap, both fed from the same stimulus.
module tb_peak_finder;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] input_data = '0;
  logic signed [15:0] threshold = 16'sd100;
  logic        [7:0]  holdoff = '0;

  logic signed [15:0] amp16, amp4;
  logic        [15:0] time16;
  logic        [3:0]  time4;
  logic               valid16, valid4, busy16, busy4;
  logic        [7:0]  count16, count4;

  peak_finder dut (
    .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
    .holdoff(holdoff), .output_amp(amp16), .output_time(time16),
    .output_valid(valid16), .output_count(count16), .busy(busy16)
  );

  peak_finder #(.TIME_W(4)) dut4 (
    .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
    .holdoff(holdoff), .output_amp(amp4), .output_time(time4),
    .output_valid(valid4), .output_count(count4), .busy(busy4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] amp;
    logic [15:0] tim;
    logic [7:0]  cnt;
  } ev_t;

  ev_t  ev[$];
  ev_t  ev4[$];
  logic bh[$];
  int   qd[$];
  int   qt[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Holds reset for two edges with the given input applied, releases at a falling edge.
  task automatic apply_reset(input int d);
    reset      = 1'b1;
    input_data = 16'(d);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ev.delete();
    ev4.delete();
    bh.delete();
  endtask

  // Presents qd[i] (and qt[i] if given) for cycle base+i, logs pulses seen after each edge.
  task automatic run(input int base);
    for (int i = 0; i < qd.size(); i++) begin
      input_data = 16'(qd[i]);
      if (i < qt.size()) threshold = 16'(qt[i]);
      @(posedge clk);
      @(negedge clk);
      if (valid16) ev.push_back(ev_t'{base + i, amp16, time16, count16});
      if (valid4)  ev4.push_back(ev_t'{base + i, amp4, {12'b0, time4}, count4});
      bh.push_back(busy16);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; input_data = 16'sd500; threshold = 16'sd100;
    @(posedge clk); @(posedge clk); @(negedge clk);
    n_cmp++; if (amp16 !== 16'd0) begin n_bad++; $display("FAIL reset_amp: got %0d want 0", amp16); end
    n_cmp++; if (time16 !== 16'd0) begin n_bad++; $display("FAIL reset_time: got %0d want 0", time16); end
    n_cmp++; if (valid16 !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid16); end
    n_cmp++; if (count16 !== 8'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count16); end
    n_cmp++; if (busy16 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy16); end
    n_cmp++; if ({busy4, valid4, time4} !== 6'd0) begin n_bad++; $display("FAIL reset_dut4: got %b want 0", {busy4, valid4, time4}); end
  endtask

  task automatic test_basic();
    threshold = 16'sd100; holdoff = 8'd0;
    apply_reset(0);
    qt.delete();
    qd = '{0, 50, 150, 300, 280, 90, 0, 0, 0};
    run(0);
    n_cmp++; if (ev.size() !== 1) begin n_bad++; $display("FAIL basic_events: got %0d want 1", ev.size()); end
    if (ev.size() > 0) begin
      n_cmp++; if (ev[0].idx !== 6) begin n_bad++; $display("FAIL basic_latency: got cycle %0d want 6", ev[0].idx); end
      n_cmp++; if (ev[0].amp !== 16'd300) begin n_bad++; $display("FAIL basic_amp: got %0d want 300", ev[0].amp); end
      n_cmp++; if (ev[0].tim !== 16'd3) begin n_bad++; $display("FAIL basic_time: got %0d want 3", ev[0].tim); end
      n_cmp++; if (ev[0].cnt !== 8'd1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", ev[0].cnt); end
    end
    n_cmp++; if ({bh[2], bh[3], bh[5], bh[6]} !== 4'b0110) begin n_bad++; $display("FAIL basic_busy: got %b want 0110", {bh[2], bh[3], bh[5], bh[6]}); end
    n_cmp++; if (amp16 !== 16'd300 || time16 !== 16'd3 || count16 !== 8'd1) begin
      n_bad++; $display("FAIL basic_hold: got amp %0d time %0d count %0d want 300 3 1", amp16, time16, count16);
    end
  endtask

  task automatic test_tie();
    apply_reset(0);
    qd = '{150, 200, 200, 50, 0, 0};
    run(0);
    n_cmp++; if (ev.size() !== 1) begin n_bad++; $display("FAIL tie_events: got %0d want 1", ev.size()); end
    if (ev.size() > 0) begin
      n_cmp++; if (ev[0].amp !== 16'd200 || ev[0].tim !== 16'd1 || ev[0].idx !== 4) begin
        n_bad++; $display("FAIL tie_peak: got amp %0d time %0d cycle %0d want 200 1 4", ev[0].amp, ev[0].tim, ev[0].idx);
      end
    end
  endtask

  task automatic test_no_cross();
    logic any_busy;
    apply_reset(0);
    qd = '{0, 100, 60, 100, -20, 100, 0, 0};
    run(0);
    any_busy = 1'b0;
    foreach (bh[i]) any_busy |= bh[i];
    n_cmp++; if (ev.size() !== 0) begin n_bad++; $display("FAIL nocross_events: got %0d want 0", ev.size()); end
    n_cmp++; if (any_busy !== 1'b0) begin n_bad++; $display("FAIL nocross_busy: got %b want 0", any_busy); end
    n_cmp++; if (count16 !== 8'd0) begin n_bad++; $display("FAIL nocross_count: got %0d want 0", count16); end
  endtask

  task automatic test_stuck();
    apply_reset(0);
    qd.delete();
    for (int i = 0; i < 24; i++) qd.push_back(150 + (i % 3));
    run(0);
    n_cmp++; if (ev.size() !== 0) begin n_bad++; $display("FAIL stuck_events: got %0d want 0", ev.size()); end
    n_cmp++; if (busy16 !== 1'b1) begin n_bad++; $display("FAIL stuck_busy: got %b want 1", busy16); end
  endtask

  task automatic test_holdoff_block();
    holdoff = 8'd4;
    apply_reset(0);
    qd = '{150, 200, 50, 0, 0, 170, 180, 0, 0, 0, 0, 0, 0};
    run(0);
    n_cmp++; if (ev.size() !== 1) begin n_bad++; $display("FAIL hold_block_events: got %0d want 1", ev.size()); end
    if (ev.size() > 0) begin
      n_cmp++; if (ev[0].idx !== 3 || ev[0].amp !== 16'd200) begin
        n_bad++; $display("FAIL hold_block_first: got cycle %0d amp %0d want 3 200", ev[0].idx, ev[0].amp);
      end
    end
    n_cmp++; if ({bh[6], bh[7]} !== 2'b10) begin n_bad++; $display("FAIL hold_block_busy: got %b want 10", {bh[6], bh[7]}); end
    n_cmp++; if (count16 !== 8'd1) begin n_bad++; $display("FAIL hold_block_count: got %0d want 1", count16); end
  endtask

  task automatic test_holdoff_pass();
    holdoff = 8'd4;
    apply_reset(0);
    qd = '{150, 200, 50, 0, 0, 0, 0, 0, 170, 250, 0, 0, 0};
    run(0);
    n_cmp++; if (ev.size() !== 2) begin n_bad++; $display("FAIL hold_pass_events: got %0d want 2", ev.size()); end
    if (ev.size() > 1) begin
      n_cmp++; if (ev[1].idx !== 11 || ev[1].amp !== 16'd250 || ev[1].tim !== 16'd9 || ev[1].cnt !== 8'd2) begin
        n_bad++; $display("FAIL hold_pass_second: got cycle %0d amp %0d time %0d count %0d want 11 250 9 2",
                          ev[1].idx, ev[1].amp, ev[1].tim, ev[1].cnt);
      end
    end
  endtask

  // holdoff drops to 0 right after the emit edge; the 4-clock dead time must still apply,
  // and the first IDLE cycle afterwards must start a new pulse.
  task automatic test_holdoff_sampled();
    holdoff = 8'd4;
    apply_reset(0);
    qd = '{150, 200, 50, 0};
    run(0);
    holdoff = 8'd0;
    qd = '{0, 0, 170, 160, 0, 0, 0};
    run(4);
    n_cmp++; if (ev.size() !== 2) begin n_bad++; $display("FAIL hold_sampled_events: got %0d want 2", ev.size()); end
    if (ev.size() > 1) begin
      n_cmp++; if (ev[1].idx !== 9 || ev[1].amp !== 16'd160 || ev[1].tim !== 16'd7) begin
        n_bad++; $display("FAIL hold_sampled_second: got cycle %0d amp %0d time %0d want 9 160 7",
                          ev[1].idx, ev[1].amp, ev[1].tim);
      end
    end
  endtask

  task automatic test_threshold_change();
    holdoff = 8'd0;
    apply_reset(0);
    qd = '{150, 200, 180, 0, 0, 0};
    qt = '{100, 100, 100, 190, 100, 100};
    run(0);
    qt.delete();
    n_cmp++; if (ev.size() !== 1) begin n_bad++; $display("FAIL thr_events: got %0d want 1", ev.size()); end
    if (ev.size() > 0) begin
      n_cmp++; if (ev[0].idx !== 3 || ev[0].amp !== 16'd200 || ev[0].tim !== 16'd1) begin
        n_bad++; $display("FAIL thr_peak: got cycle %0d amp %0d time %0d want 3 200 1", ev[0].idx, ev[0].amp, ev[0].tim);
      end
    end
  endtask

  task automatic test_negative();
    threshold = -16'sd500; holdoff = 8'd0;
    apply_reset(0);
    qd = '{-1000, -300, -100, -200, -600, -1000, -1000};
    run(0);
    n_cmp++; if (ev.size() !== 1) begin n_bad++; $display("FAIL neg_events: got %0d want 1", ev.size()); end
    if (ev.size() > 0) begin
      n_cmp++; if (ev[0].amp !== 16'hFF9C || ev[0].tim !== 16'd2 || ev[0].idx !== 5) begin
        n_bad++; $display("FAIL neg_peak: got amp %h time %0d cycle %0d want ff9c 2 5", ev[0].amp, ev[0].tim, ev[0].idx);
      end
    end
    threshold = 16'sd100;
  endtask

  task automatic test_time_wrap_and_reset();
    threshold = 16'sd100; holdoff = 8'd0;
    apply_reset(0);
    qd.delete();
    for (int i = 0; i < 17; i++) qd.push_back(0);
    qd.push_back(150); qd.push_back(300);
    for (int i = 0; i < 5; i++) qd.push_back(0);
    run(0);
    n_cmp++; if (ev4.size() !== 1) begin n_bad++; $display("FAIL wrap_events: got %0d want 1", ev4.size()); end
    if (ev4.size() > 0) begin
      n_cmp++; if (ev4[0].tim !== 16'd2 || ev4[0].amp !== 16'd300 || ev4[0].idx !== 20) begin
        n_bad++; $display("FAIL wrap_peak: got time %0d amp %0d cycle %0d want 2 300 20", ev4[0].tim, ev4[0].amp, ev4[0].idx);
      end
    end
    n_cmp++; if (time16 !== 16'd18) begin n_bad++; $display("FAIL wrap_wide_time: got %0d want 18", time16); end
    // Pulse rising at cycles 24..25; reset hits while the peak is on the input.
    qd = '{150, 200};
    run(24);
    n_cmp++; if (busy4 !== 1'b1) begin n_bad++; $display("FAIL midpulse_tracking: got %b want 1", busy4); end
    apply_reset(300);
    n_cmp++; if (busy4 !== 1'b0 || count4 !== 8'd0) begin
      n_bad++; $display("FAIL midpulse_reset: got busy %b count %0d want 0 0", busy4, count4);
    end
    qd = '{0, 150, 250, 0, 0, 0};
    run(0);
    n_cmp++; if (ev4.size() !== 1 || ev.size() !== 1) begin
      n_bad++; $display("FAIL after_reset_events: got %0d/%0d want 1/1", ev4.size(), ev.size());
    end
    if (ev4.size() > 0) begin
      n_cmp++; if (ev4[0].idx !== 4 || ev4[0].tim !== 16'd2 || ev4[0].amp !== 16'd250 || ev4[0].cnt !== 8'd1) begin
        n_bad++; $display("FAIL after_reset_peak: got cycle %0d time %0d amp %0d count %0d want 4 2 250 1",
                          ev4[0].idx, ev4[0].tim, ev4[0].amp, ev4[0].cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_no_cross();
    test_stuck();
    test_holdoff_block();
    test_holdoff_pass();
    test_holdoff_sampled();
    test_threshold_change();
    test_negative();
    test_time_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
